// File: rtl/mvau_defn.sv
// Shared definitions for the matrix-vector activation stream unit:
// default geometry, fold helpers and the per-element product rules.
package mvau_defn;

  localparam int unsigned DEF_MATRIX_W = 16;
  localparam int unsigned DEF_MATRIX_H = 16;
  localparam int unsigned DEF_SIMD     = 2;
  localparam int unsigned DEF_PE       = 2;
  localparam int unsigned DEF_TSRCI    = 4;
  localparam int unsigned DEF_TW       = 4;
  localparam int unsigned DEF_TDSTI    = 16;

  function automatic int unsigned fold_count(input int unsigned total, input int unsigned per);
    return total / per;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One weight x activation term as a 64-bit two's complement value; callers truncate.
  function automatic logic [63:0] prod(input logic [31:0] w, input logic [31:0] a,
                                       input bit w_bin, input bit a_bin, input bit xnor_mode);
    if (xnor_mode) begin
      return {63'd0, ~(w[0] ^ a[0])};
    end
    if (a_bin) begin
      return a[0] ? 64'(w) : -64'(w);
    end
    if (w_bin) begin
      return w[0] ? 64'(a) : -64'(a);
    end
    return 64'(w) * 64'(a);
  endfunction

endpackage

// File: rtl/mvau_stream_bp_if.sv
// Activation, weight and result streams of the matrix-vector unit, each with valid/ready.
interface mvau_stream_bp_if
  import mvau_defn::*;
#(
  parameter int unsigned SIMD  = DEF_SIMD,
  parameter int unsigned PE    = DEF_PE,
  parameter int unsigned TSrcI = DEF_TSRCI,
  parameter int unsigned TW    = DEF_TW,
  parameter int unsigned TDstI = DEF_TDSTI
) ();

  typedef logic [SIMD*TSrcI-1:0]  act_vec_t;
  typedef logic [PE*SIMD*TW-1:0]  wgt_vec_t;
  typedef logic [PE*TDstI-1:0]    out_vec_t;

  logic     in_v;
  logic     in_rdy;
  act_vec_t in_act;
  logic     in_wgt_v;
  logic     in_wgt_rdy;
  wgt_vec_t in_wgt;
  logic     out_v;
  logic     out_rdy;
  out_vec_t out;

  modport slave (
    input  in_v, in_act, in_wgt_v, in_wgt, out_rdy,
    output in_rdy, in_wgt_rdy, out_v, out
  );

  modport master (
    output in_v, in_act, in_wgt_v, in_wgt, out_rdy,
    input  in_rdy, in_wgt_rdy, out_v, out
  );

endinterface

// File: rtl/mvau_stream_act_buf.sv
// Activation vector store: one SIMD-wide word per synapse fold, written on the first
// neuron fold and read back for the remaining folds.
module mvau_stream_act_buf
  import mvau_defn::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/mvau_stream_bp.sv
// Matrix-vector activation stream unit with valid/ready on activation, weight and result streams.
// Each activation vector is accepted once and replayed from a local buffer for every neuron fold.
module mvau_stream_bp
  import mvau_defn::*;
#(
  parameter int unsigned MatrixW   = DEF_MATRIX_W,
  parameter int unsigned MatrixH   = DEF_MATRIX_H,
  parameter int unsigned SIMD      = DEF_SIMD,
  parameter int unsigned PE        = DEF_PE,
  parameter int unsigned TSrcI     = DEF_TSRCI,
  parameter int unsigned TSrcI_BIN = 0,
  parameter int unsigned TW        = DEF_TW,
  parameter int unsigned TW_BIN    = 0,
  parameter int unsigned TDstI     = DEF_TDSTI
) (
  input  logic            clk,
  input  logic            rst,
  mvau_stream_bp_if.slave bus
);

  localparam int unsigned SF    = fold_count(MatrixW, SIMD);
  localparam int unsigned NF    = fold_count(MatrixH, PE);
  localparam int unsigned SFW   = idx_width(SF);
  localparam int unsigned NFW   = idx_width(NF);
  localparam int unsigned ACT_W = SIMD * TSrcI;
  localparam bit A_BIN     = (TSrcI_BIN != 0);
  localparam bit W_BIN     = (TW_BIN != 0);
  localparam bit XNOR_MODE = A_BIN && W_BIN && (TW == 1) && (TSrcI == 1);

  logic [SFW-1:0]             sf_q;
  logic [NFW-1:0]             nf_q;
  logic                       out_v_q;
  logic [PE-1:0][TDstI-1:0]   acc_q;
  logic [PE-1:0][TDstI-1:0]   out_q;

  logic                       nf_zero_c;
  logic                       last_sf_c;
  logic                       last_nf_c;
  logic                       blocked_c;
  logic                       act_ok_c;
  logic                       fire_c;
  logic [ACT_W-1:0]           buf_rd_c;
  logic [ACT_W-1:0]           act_c;
  logic [PE-1:0][TDstI-1:0]   dot_c;
  logic [PE-1:0][TDstI-1:0]   sum_c;

  mvau_stream_act_buf #(
    .DEPTH (SF),
    .WIDTH (ACT_W),
    .AW    (SFW)
  ) u_act_buf (
    .clk     (clk),
    .we      (fire_c & nf_zero_c),
    .waddr   (sf_q),
    .wdata   (bus.in_act),
    .raddr   (sf_q),
    .rdata_c (buf_rd_c)
  );

  // Handshake: only the last beat of a fold waits for the result register to free up.
  always_comb begin
    nf_zero_c = (nf_q == '0);
    last_sf_c = (sf_q == SFW'(SF - 1));
    last_nf_c = (nf_q == NFW'(NF - 1));
    blocked_c = last_sf_c & out_v_q & ~bus.out_rdy;
    act_ok_c  = nf_zero_c ? bus.in_v : 1'b1;
    fire_c    = act_ok_c & bus.in_wgt_v & ~blocked_c;
    act_c     = nf_zero_c ? bus.in_act : buf_rd_c;
  end

  assign bus.in_rdy     = nf_zero_c & bus.in_wgt_v & ~blocked_c;
  assign bus.in_wgt_rdy = act_ok_c & ~blocked_c;
  assign bus.out_v      = out_v_q;
  assign bus.out        = out_q;

  // Per-PE dot product of one beat, then fold accumulation restarting at sf == 0.
  always_comb begin
    for (int unsigned p = 0; p < PE; p++) begin
      dot_c[p] = '0;
      for (int unsigned k = 0; k < SIMD; k++) begin
        dot_c[p] = dot_c[p] + TDstI'(prod(32'(bus.in_wgt[(p*SIMD + k)*TW +: TW]),
                                          32'(act_c[k*TSrcI +: TSrcI]),
                                          W_BIN, A_BIN, XNOR_MODE));
      end
      sum_c[p] = ((sf_q == '0) ? '0 : acc_q[p]) + dot_c[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_q    <= '0;
      nf_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      if (fire_c) begin
        acc_q <= sum_c;
        sf_q  <= last_sf_c ? '0 : sf_q + SFW'(1);
        if (last_sf_c) begin
          out_q <= sum_c;
          nf_q  <= last_nf_c ? '0 : nf_q + NFW'(1);
        end
      end
      // A drain coinciding with a new result keeps out_v high.
      if (fire_c && last_sf_c) begin
        out_v_q <= 1'b1;
      end else if (bus.out_rdy) begin
        out_v_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvau_stream_bp.sv
// Bench for mvau_stream_bp: randomized streams with a scoreboard fed by a matrix-vector
// reference model, plus fixed-input instances for the binary and wrap-around variants.
module tb_mvau_stream_bp;

  localparam int MW = 8;
  localparam int MH = 4;
  localparam int S  = 2;
  localparam int P  = 2;
  localparam int TA = 4;
  localparam int TWW = 4;
  localparam int TD = 16;
  localparam int SF = MW / S;
  localparam int NF = MH / P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [S*TA-1:0]    act_q [$];
  logic [P*S*TWW-1:0] wgt_q [$];
  logic [P*TD-1:0]    exp_q [$];

  mvau_stream_bp_if #(.SIMD(S), .PE(P), .TSrcI(TA), .TW(TWW), .TDstI(TD)) bus ();
  mvau_stream_bp #(.MatrixW(MW), .MatrixH(MH), .SIMD(S), .PE(P), .TSrcI(TA), .TSrcI_BIN(0),
                   .TW(TWW), .TW_BIN(0), .TDstI(TD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  mvau_stream_bp_if #(.SIMD(2), .PE(2), .TSrcI(1), .TW(1), .TDstI(16)) b3 ();
  mvau_stream_bp #(.MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .TSrcI(1), .TSrcI_BIN(1),
                   .TW(1), .TW_BIN(1), .TDstI(16))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  mvau_stream_bp_if #(.SIMD(2), .PE(2), .TSrcI(1), .TW(4), .TDstI(16)) b4 ();
  mvau_stream_bp #(.MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .TSrcI(1), .TSrcI_BIN(1),
                   .TW(4), .TW_BIN(0), .TDstI(16))
    dut4 (.clk(clk), .rst(rst), .bus(b4));

  mvau_stream_bp_if #(.SIMD(2), .PE(2), .TSrcI(4), .TW(4), .TDstI(8)) b6 ();
  mvau_stream_bp #(.MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .TSrcI(4), .TSrcI_BIN(0),
                   .TW(4), .TW_BIN(0), .TDstI(8))
    dut6 (.clk(clk), .rst(rst), .bus(b6));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain matrix-vector product over the whole vector, modulo 2^TD.
  task automatic gen_vec(input bit ones);
    int a [SF*S];
    int w [MH][MW];
    logic [S*TA-1:0]    ab;
    logic [P*S*TWW-1:0] wb;
    logic [P*TD-1:0]    r;
    int sum;
    for (int c = 0; c < MW; c++) a[c] = ones ? 1 : int'($urandom_range(0, 15));
    for (int row = 0; row < MH; row++)
      for (int c = 0; c < MW; c++) w[row][c] = ones ? 1 : int'($urandom_range(0, 15));
    for (int s = 0; s < SF; s++) begin
      for (int k = 0; k < S; k++) ab[k*TA +: TA] = TA'(a[s*S + k]);
      act_q.push_back(ab);
    end
    for (int n = 0; n < NF; n++)
      for (int s = 0; s < SF; s++) begin
        for (int p = 0; p < P; p++)
          for (int k = 0; k < S; k++) wb[(p*S + k)*TWW +: TWW] = TWW'(w[n*P + p][s*S + k]);
        wgt_q.push_back(wb);
      end
    for (int n = 0; n < NF; n++) begin
      for (int p = 0; p < P; p++) begin
        sum = 0;
        for (int c = 0; c < MW; c++) sum += w[n*P + p][c] * a[c];
        r[p*TD +: TD] = TD'(sum);
      end
      exp_q.push_back(r);
    end
  endtask

  // One clock of stimulus: pop accepted beats, hold unaccepted ones, maybe offer new ones.
  task automatic step(input int pv, input int pw, input int po);
    logic ah, wh;
    @(negedge clk);
    ah = !rst && bus.in_v && bus.in_rdy;
    wh = !rst && bus.in_wgt_v && bus.in_wgt_rdy;
    @(posedge clk);
    #1;
    if (ah) void'(act_q.pop_front());
    if (wh) void'(wgt_q.pop_front());
    if (!bus.in_v || ah) begin
      bus.in_v   = (act_q.size() > 0) && (int'($urandom_range(0, 99)) < pv);
      bus.in_act = (act_q.size() > 0) ? act_q[0] : '0;
    end
    if (!bus.in_wgt_v || wh) begin
      bus.in_wgt_v = (wgt_q.size() > 0) && (int'($urandom_range(0, 99)) < pw);
      bus.in_wgt   = (wgt_q.size() > 0) ? wgt_q[0] : '0;
    end
    bus.out_rdy = int'($urandom_range(0, 99)) < po;
  endtask

  task automatic run(input int pv, input int pw, input int po);
    int guard = 0;
    while ((act_q.size() > 0 || wgt_q.size() > 0 || exp_q.size() > 0) && guard < 5000) begin
      step(pv, pw, po);
      guard++;
    end
    chk("drain_in_time", 64'(guard < 5000), 64'd1);
  endtask

  // Monitor: handshake rules from bench-side beat counting, output hold, scoreboard pops.
  int wcnt = 0;
  int pos;
  logic nf0, lastb, blk, a_hs, w_hs, hold_v;
  logic [P*TD-1:0] hold_out;
  always @(negedge clk) begin
    if (rst) begin
      wcnt   = 0;
      hold_v = 1'b0;
    end else begin
      pos   = wcnt % (SF*NF);
      nf0   = pos < SF;
      lastb = (pos % SF) == SF - 1;
      blk   = lastb & bus.out_v & ~bus.out_rdy;
      a_hs  = bus.in_v & bus.in_rdy;
      w_hs  = bus.in_wgt_v & bus.in_wgt_rdy;
      chk("in_wgt_rdy", 64'(bus.in_wgt_rdy), 64'((nf0 ? bus.in_v : 1'b1) & ~blk));
      chk("in_rdy", 64'(bus.in_rdy), 64'(nf0 & bus.in_wgt_v & ~blk));
      chk("act_only_first_fold", 64'(a_hs), 64'(w_hs & nf0));
      if (hold_v) begin
        chk("hold_out_v", 64'(bus.out_v), 64'd1);
        chk("hold_out", 64'(bus.out), 64'(hold_out));
      end
      if (bus.out_v && bus.out_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_result", 64'(bus.out), 64'hDEAD);
        else chk("result", 64'(bus.out), 64'(exp_q.pop_front()));
      end
      hold_v   = bus.out_v & ~bus.out_rdy;
      hold_out = bus.out;
      if (w_hs) wcnt++;
    end
  end

  // Fixed-input variants: every presented result must equal the hand-derived constant.
  int n3 = 0, n4 = 0, n6 = 0;
  initial begin
    b3.in_v = 1'b1; b3.in_wgt_v = 1'b1; b3.out_rdy = 1'b1;
    b3.in_act = 2'b11; b3.in_wgt = 4'b0101;
    b4.in_v = 1'b1; b4.in_wgt_v = 1'b1; b4.out_rdy = 1'b1;
    b4.in_act = 2'b00; b4.in_wgt = 16'h3333;
    b6.in_v = 1'b1; b6.in_wgt_v = 1'b1; b6.out_rdy = 1'b1;
    b6.in_act = 8'hFF; b6.in_wgt = 16'hFFFF;
  end
  always @(negedge clk) begin
    if (!rst && b3.out_v) begin chk("bin_xnor", 64'(b3.out), 64'h0004_0004); n3++; end
    if (!rst && b4.out_v) begin chk("act_bin_neg", 64'(b4.out), 64'hFFE8_FFE8); n4++; end
    if (!rst && b6.out_v) begin chk("wrap_8bit", 64'(b6.out), 64'h0808); n6++; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    bus.in_v = 1'b0; bus.in_wgt_v = 1'b0; bus.out_rdy = 1'b0;
    bus.in_act = '0; bus.in_wgt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_v", 64'(bus.out_v), 64'd0);
    chk("reset_out", 64'(bus.out), 64'd0);
    chk("reset_in_rdy", 64'(bus.in_rdy), 64'd0);
    @(posedge clk);
    #1;

    // All-ones vector, no backpressure.
    gen_vec(1'b1);
    run(100, 100, 100);

    // All-ones vector with the result stalled, then released.
    gen_vec(1'b1);
    repeat (20) step(100, 100, 0);
    run(100, 100, 100);

    // Reset two beats into a vector; the partial vector is discarded.
    gen_vec(1'b0);
    guard = 0;
    while (wcnt < 2 && guard < 50) begin
      step(100, 100, 100);
      guard++;
    end
    chk("pre_reset_beats", 64'(wcnt >= 2), 64'd1);
    rst = 1'b1;
    act_q.delete(); wgt_q.delete(); exp_q.delete();
    bus.in_v = 1'b0; bus.in_wgt_v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    gen_vec(1'b1);
    bus.in_wgt_v = 1'b1; bus.in_wgt = wgt_q[0]; bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("post_reset_out_v", 64'(bus.out_v), 64'd0);
    chk("post_reset_out", 64'(bus.out), 64'd0);
    chk("post_reset_in_rdy", 64'(bus.in_rdy), 64'(bus.in_wgt_v));
    chk("post_reset_wgt_rdy", 64'(bus.in_wgt_rdy), 64'd0);
    @(posedge clk);
    #1;
    run(100, 100, 100);

    // Random vectors with random stalls on every stream.
    repeat (40) gen_vec(1'b0);
    run(70, 70, 60);
    repeat (5) step(0, 0, 100);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("bin_xnor_seen", 64'(n3 > 0), 64'd1);
    chk("act_bin_seen", 64'(n4 > 0), 64'd1);
    chk("wrap_seen", 64'(n6 > 0), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
